// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter.
// Direction and boundary-mode encodings used by the counter and its checker.
package param_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/param_counter_sva.sv
// Observe-only assertion checker for param_counter; every input is a tap, nothing is driven back.
// Compiled into the counter only when PARAM_COUNTER_SVA_EN is defined.
module param_counter_sva
  import param_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = MODE_WRAP
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  input logic             dir,
  input logic             clr,
  input logic             load,
  input logic [WIDTH-1:0] load_val,
  input logic             ovf_clr,
  input logic [WIDTH-1:0] count,
  input logic             tc,
  input logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic             event_hit;
  logic [WIDTH-1:0] clamp_v;
  logic [WIDTH-1:0] bound_v;

  always_comb begin
    event_hit = en & ~clr & ~load &
                ((dir == DIR_UP) ? (count == MAX_CNT) : (count == '0));
    clamp_v   = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    bound_v   = count;
    if (SATURATE == MODE_WRAP) bound_v = (dir == DIR_UP) ? '0 : MAX_CNT;
  end

  a_rst_val: assert property (@(posedge clk) !rst_n |-> (count == '0) && !tc && !ovf);

  a_range: assert property (@(posedge clk) disable iff (!rst_n) count <= MAX_CNT);

  a_clr: assert property (@(posedge clk) disable iff (!rst_n)
    clr |=> (count == '0) && !tc);

  a_load: assert property (@(posedge clk) disable iff (!rst_n)
    (!clr && load) |=> (count == $past(clamp_v)) && !tc);

  a_up: assert property (@(posedge clk) disable iff (!rst_n)
    (en && !clr && !load && dir == DIR_UP && count != MAX_CNT) |=> count == $past(count) + 1'b1);

  a_down: assert property (@(posedge clk) disable iff (!rst_n)
    (en && !clr && !load && dir == DIR_DOWN && count != '0) |=> count == $past(count) - 1'b1);

  a_bound: assert property (@(posedge clk) disable iff (!rst_n)
    event_hit |=> tc && ovf && (count == $past(bound_v)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!clr && !load && !en) |=> count == $past(count));

  a_tc_pulse: assert property (@(posedge clk) disable iff (!rst_n) !event_hit |=> !tc);

  a_ovf_keep: assert property (@(posedge clk) disable iff (!rst_n) (ovf && !ovf_clr) |=> ovf);

  a_ovf_clr: assert property (@(posedge clk) disable iff (!rst_n)
    (!event_hit && ovf_clr) |=> !ovf);

endmodule

// File: rtl/param_counter.sv
// Up/down counter with terminal value MAX_VAL, wrap or saturate at the bounds, tc pulse and sticky ovf.
// Define PARAM_COUNTER_SVA_EN to embed the param_counter_sva checker.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic             event_hit;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_nxt;

  // Boundary steps never reach the +/-1 path, so WIDTH-bit arithmetic cannot overflow.
  always_comb begin
    event_hit = en & ~clr & ~load &
                ((dir == DIR_UP) ? (count == MAX_CNT) : (count == '0));
    step_val  = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
    if (event_hit) begin
      step_val = count;
      if (SATURATE == MODE_WRAP) step_val = (dir == DIR_UP) ? '0 : MAX_CNT;
    end
    count_nxt = count;
    if (clr)       count_nxt = '0;
    else if (load) count_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    else if (en)   count_nxt = step_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= event_hit;
      ovf   <= event_hit | (ovf & ~ovf_clr);
    end
  end

`ifdef PARAM_COUNTER_SVA_EN
  param_counter_sva #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_sva (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );
`else
  // Checker-free build: the counter logic above is the whole design.
`endif

endmodule

// File: tb/tb_param_counter.sv
// Drives three counter configurations (31/wrap, 9/wrap, 9/saturate) from shared inputs;
// expected outputs are queued when each step is driven and popped after the clock edge.
module tb_param_counter;
  import param_counter_pkg::*;

  typedef struct packed {
    logic [4:0] cnt;
    logic       tc;
    logic       ovf;
  } obs_t;
  typedef obs_t [2:0] obs3_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  int    total = 0;
  int    bad = 0;
  obs3_t sb_q[$];
  int    m_cnt[3] = '{0, 0, 0};
  bit    m_ovf[3] = '{0, 0, 0};
  int    cfg_max[3] = '{31, 9, 9};
  bit    cfg_sat[3] = '{0, 0, 1};

  always #5 clk = ~clk;

  param_counter #(.WIDTH(5), .MAX_VAL(31), .SATURATE(MODE_WRAP)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));

  param_counter #(.WIDTH(5), .MAX_VAL(9), .SATURATE(MODE_WRAP)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));

  param_counter #(.WIDTH(5), .MAX_VAL(9), .SATURATE(MODE_SAT)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

  function automatic obs3_t observe();
    obs3_t o;
    o[0] = '{cnt: cnt_a, tc: tc_a, ovf: ovf_a};
    o[1] = '{cnt: cnt_b, tc: tc_b, ovf: ovf_b};
    o[2] = '{cnt: cnt_c, tc: tc_c, ovf: ovf_c};
    return o;
  endfunction

  task automatic model_push();
    obs3_t e;
    for (int i = 0; i < 3; i++) begin
      int n;
      bit ev;
      n  = m_cnt[i];
      ev = 1'b0;
      if (clr) n = 0;
      else if (load) n = (int'(load_val) > cfg_max[i]) ? cfg_max[i] : int'(load_val);
      else if (en) begin
        if (dir) begin
          if (m_cnt[i] == cfg_max[i]) begin ev = 1'b1; n = cfg_sat[i] ? m_cnt[i] : 0; end
          else n = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin ev = 1'b1; n = cfg_sat[i] ? 0 : cfg_max[i]; end
          else n = m_cnt[i] - 1;
        end
      end
      m_ovf[i] = ev | (m_ovf[i] & ~ovf_clr);
      m_cnt[i] = n;
      e[i].cnt = 5'(n);
      e[i].tc  = ev;
      e[i].ovf = m_ovf[i];
    end
    sb_q.push_back(e);
  endtask

  task automatic sb_check(string tag);
    obs3_t o, e;
    o = observe();
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=%h required=one queued entry", tag, o);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        total++;
        assert (o[i] === e[i]) else begin
          bad++;
          $error("FAIL %s inst%0d observed cnt=%0d tc=%b ovf=%b expected cnt=%0d tc=%b ovf=%b",
                 tag, i, o[i].cnt, o[i].tc, o[i].ovf, e[i].cnt, e[i].tc, e[i].ovf);
        end
      end
    end
  endtask

  task automatic check_val(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(string tag, bit s_en, bit s_dir, bit s_clr, bit s_load,
                      logic [4:0] s_lv, bit s_oc);
    en = s_en; dir = s_dir; clr = s_clr; load = s_load; load_val = s_lv; ovf_clr = s_oc;
    model_push();
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_val("rst_cnt_a", int'(cnt_a), 0);
    check_val("rst_tc_a", int'(tc_a), 0);
    check_val("rst_ovf_c", int'(ovf_c), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // load then asynchronous reset mid-cycle at count 13
    step("load13", 0, 1, 0, 1, 5'd13, 0);
    check_val("load13_a", int'(cnt_a), 13);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_cnt_a", int'(cnt_a), 0);
    check_val("async_tc_a", int'(tc_a), 0);
    check_val("async_ovf_a", int'(ovf_a), 0);
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 0, 1, 0, 0, 5'd0, 0);

    // wrap up at 31
    step("load31", 0, 1, 0, 1, 5'd31, 0);
    step("wrap_up", 1, 1, 0, 0, 5'd0, 0);
    check_val("wrap_cnt_a", int'(cnt_a), 0);
    check_val("wrap_tc_a", int'(tc_a), 1);
    check_val("wrap_ovf_a", int'(ovf_a), 1);
    step("idle", 0, 1, 0, 0, 5'd0, 0);
    check_val("tc_drop_a", int'(tc_a), 0);

    // modulo-10 down
    step("clr", 0, 0, 1, 0, 5'd0, 0);
    step("down_wrap", 1, 0, 0, 0, 5'd0, 0);
    check_val("down_cnt_b", int'(cnt_b), 9);
    check_val("down_tc_b", int'(tc_b), 1);
    step("down_next", 1, 0, 0, 0, 5'd0, 0);
    check_val("down2_cnt_b", int'(cnt_b), 8);
    check_val("down2_tc_b", int'(tc_b), 0);

    // saturate hold for three edges
    step("load9", 0, 1, 0, 1, 5'd9, 0);
    for (int k = 0; k < 3; k++) begin
      step("sat_up", 1, 1, 0, 0, 5'd0, 0);
      check_val("sat_cnt_c", int'(cnt_c), 9);
      check_val("sat_tc_c", int'(tc_c), 1);
    end

    // priority and load clamp
    step("prio", 1, 1, 1, 1, 5'd20, 0);
    check_val("prio_cnt_a", int'(cnt_a), 0);
    step("clamp", 0, 1, 0, 1, 5'd20, 0);
    check_val("clamp_cnt_b", int'(cnt_b), 9);
    check_val("clamp_cnt_a", int'(cnt_a), 20);

    // ovf: event and ovf_clr together keep it set
    step("ovf_clr0", 0, 1, 0, 0, 5'd0, 1);
    check_val("ovf_cleared_a", int'(ovf_a), 0);
    step("load31b", 0, 1, 0, 1, 5'd31, 0);
    step("ovf_race", 1, 1, 0, 0, 5'd0, 1);
    check_val("ovf_race_a", int'(ovf_a), 1);
    step("ovf_clr1", 0, 1, 0, 0, 5'd0, 1);
    check_val("ovf_clr1_a", int'(ovf_a), 0);

    // random mixed traffic
    for (int k = 0; k < 300; k++) begin
      step("rand", $urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)),
           $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0,
           5'($urandom_range(31, 0)), $urandom_range(7, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
